multicycle_divider: RTL and testbench

MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 26 ++
 rtl/multicycle_divider.sv | 139 +++++++++++++
 tb/tb_multicycle_divider.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the multicycle restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract divisor, select.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;
  logic           borrow;

  // rem_i < dvs_i always holds, so shl < 2*dvs_i: a successful difference is below
  // 2^WIDTH and a failed one wraps to at least 2^WIDTH, making the top bit the borrow.
  always_comb begin
    shl    = {rem_i, quo_i[WIDTH-1]};
    diff   = shl - {1'b0, dvs_i};
    borrow = diff[WIDTH];
    rem_o  = borrow ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/multicycle_divider.sv
// Signed/unsigned multicycle divider: one quotient bit per cycle, then sign fix-up.
module multicycle_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_n_q, sgn_n_d;
  logic             sgn_d_q, sgn_d_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dz_out_q, dz_out_d;

  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sgn_n_d    = sgn_n_q;
    sgn_d_d    = sgn_d_q;
    dz_d       = dz_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dz_out_d   = dz_out_q;
    busy_d     = (state_q == CALC) || (state_q == FIX);
    valid_d    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          sgn_n_d = is_signed & dividend[WIDTH-1];
          sgn_d_d = is_signed & divisor[WIDTH-1];
          quo_d   = sgn_n_d ? -dividend : dividend;
          dvs_d   = sgn_d_d ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = CALC;
          // Zero divisor: preload the defined result and skip the iteration.
          if (divisor == '0) begin
            dz_d    = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (sgn_n_q ^ sgn_d_q) quo_d = -quo_q;
        if (sgn_n_q)           rem_d = -rem_q;
        state_d = DONE;
      end
      DONE: begin
        quot_out_d = quo_q;
        rem_out_d  = rem_q;
        dz_out_d   = dz_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sgn_n_q    <= 1'b0;
      sgn_d_q    <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dz_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sgn_n_q    <= sgn_n_d;
      sgn_d_q    <= sgn_d_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dz_out_q   <= dz_out_d;
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Scoreboard bench: WIDTH=8 and WIDTH=32 dividers against an arithmetic reference model.
module tb_multicycle_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        s8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, val8, dz8;
  logic [7:0]  q8o, r8o;

  logic        s32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, val32, dz32;
  logic [31:0] q32o, r32o;

  exp_t sb8[$];
  exp_t sb32[$];
  exp_t e8, e32;
  int   n_vec = 0;
  int   n_err = 0;

  multicycle_divider #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .start(s8), .is_signed(sg8), .dividend(a8), .divisor(b8),
    .busy(busy8), .valid(val8), .quotient(q8o), .remainder(r8o), .div_by_zero(dz8)
  );

  multicycle_divider #(.WIDTH(32)) u32 (
    .CLK(CLK), .RST(RST), .start(s32), .is_signed(sg32), .dividend(a32), .divisor(b32),
    .busy(busy32), .valid(val32), .quotient(q32o), .remainder(r32o), .div_by_zero(dz32)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Truncating division semantics of SV integers give the required remainder sign.
  function automatic exp_t model(input int w, input bit sgn, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      e.q = mask; e.r = a & mask; e.dz = 1'b1;
    end else if (sgn) begin
      sa  = longint'(a << (64 - w)) >>> (64 - w);
      sbv = longint'(b << (64 - w)) >>> (64 - w);
      e.q = 64'(sa / sbv) & mask;
      e.r = 64'(sa % sbv) & mask;
      e.dz = 1'b0;
    end else begin
      e.q = (a / b) & mask; e.r = (a % b) & mask; e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (val8) begin
      if (sb8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL w8 unexpected valid: got q=%0h r=%0h, required no valid", q8o, r8o);
      end else begin
        e8 = sb8.pop_front();
        chk("w8 quotient", 64'(q8o), e8.q);
        chk("w8 remainder", 64'(r8o), e8.r);
        chk("w8 div_by_zero", 64'(dz8), 64'(e8.dz));
      end
    end
  end

  always @(negedge CLK) begin
    if (val32) begin
      if (sb32.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL w32 unexpected valid: got q=%0h r=%0h, required no valid", q32o, r32o);
      end else begin
        e32 = sb32.pop_front();
        chk("w32 quotient", 64'(q32o), e32.q);
        chk("w32 remainder", 64'(r32o), e32.r);
        chk("w32 div_by_zero", 64'(dz32), 64'(e32.dz));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the valid cycle (first IDLE cycle).
  task automatic run8(input bit sg, input logic [7:0] a, input logic [7:0] b);
    int lat, bcnt;
    s8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    sb8.push_back(model(8, sg, 64'(a), 64'(b)));
    @(posedge CLK); @(negedge CLK);
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!val8 && lat < 60) begin
      bcnt += int'(busy8);
      @(posedge CLK); @(negedge CLK);
      lat++;
    end
    chk("w8 latency", 64'(lat), (b == 8'd0) ? 64'd1 : 64'd10);
    chk("w8 busy cycles", 64'(bcnt), (b == 8'd0) ? 64'd0 : 64'd9);
  endtask

  task automatic run32(input bit sg, input logic [31:0] a, input logic [31:0] b);
    int lat, bcnt;
    s32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
    sb32.push_back(model(32, sg, 64'(a), 64'(b)));
    @(posedge CLK); @(negedge CLK);
    s32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!val32 && lat < 100) begin
      bcnt += int'(busy32);
      @(posedge CLK); @(negedge CLK);
      lat++;
    end
    chk("w32 latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd34);
    chk("w32 busy cycles", 64'(bcnt), (b == 32'd0) ? 64'd0 : 64'd33);
  endtask

  task automatic rand8();
    int m; logic [7:0] a, b;
    for (int i = 0; i < 500; i++) begin
      m = int'($urandom_range(0, 9));
      a = (m == 3 || m == 4) ? 8'h80 : 8'($urandom);
      b = (m == 0) ? 8'h00 : (m == 1 || m == 4) ? 8'hFF :
          (m == 2) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      run8(1'($urandom), a, b);
    end
  endtask

  task automatic rand32();
    int m; logic [31:0] a, b;
    for (int i = 0; i < 500; i++) begin
      m = int'($urandom_range(0, 9));
      a = (m == 3 || m == 4) ? 32'h8000_0000 : $urandom;
      b = (m == 0) ? 32'h0 : (m == 1 || m == 4) ? 32'hFFFF_FFFF :
          (m == 2) ? $urandom_range(1, 3) : (m == 5) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      run32(1'($urandom), a, b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset valid", 64'(val8), 64'd0);
    chk("reset quotient", 64'(q8o), 64'd0);
    chk("reset remainder", 64'(r8o), 64'd0);
    chk("reset div_by_zero", 64'(dz8), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    run8(1'b0, 8'd200, 8'd7);
    repeat (3) @(negedge CLK);
    chk("w8 hold quotient", 64'(q8o), 64'd28);
    chk("w8 hold remainder", 64'(r8o), 64'd4);
    run8(1'b1, 8'hF9, 8'd2);
    run8(1'b1, 8'd7, 8'hFE);
    run8(1'b1, 8'd13, 8'd0);
    run8(1'b0, 8'd13, 8'd0);
    run8(1'b1, 8'h80, 8'hFF);
    run8(1'b0, 8'h80, 8'hFF);

    // A second start mid-computation must vanish without a trace.
    s8 = 1'b1; sg8 = 1'b0; a8 = 8'd100; b8 = 8'd9;
    sb8.push_back(model(8, 1'b0, 64'd100, 64'd9));
    @(posedge CLK); @(negedge CLK);
    s8 = 1'b0;
    repeat (3) @(negedge CLK);
    s8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
    @(negedge CLK);
    s8 = 1'b0;
    for (int i = 0; i < 30 && sb8.size() != 0; i++) begin
      @(negedge CLK); #1;
    end
    chk("w8 pending after ignored start", 64'(sb8.size()), 64'd0);
    repeat (15) @(negedge CLK);
    chk("w8 quotient after ignored start", 64'(q8o), 64'd11);

    // Reset mid-computation aborts it.
    s8 = 1'b1; sg8 = 1'b0; a8 = 8'd77; b8 = 8'd5;
    @(posedge CLK); @(negedge CLK);
    s8 = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort valid", 64'(val8), 64'd0);
    chk("abort quotient", 64'(q8o), 64'd0);
    chk("abort remainder", 64'(r8o), 64'd0);
    chk("abort div_by_zero", 64'(dz8), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    run8(1'b0, 8'd9, 8'd3);

    fork
      rand8();
      rand32();
    join
    repeat (3) @(negedge CLK);
    chk("w8 scoreboard drained", 64'(sb8.size()), 64'd0);
    chk("w32 scoreboard drained", 64'(sb32.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
